// File: rtl/pfa_chunked.sv
// Chunked adder/subtractor: SIZE-bit operands summed CHUNK bits per cycle, LSB chunk first, with valid/ready on both sides.
// Define PFA_OVF_EN to add the signed-overflow output ovf.
module pfa_chunked #(
  parameter int SIZE  = 16,
  parameter int CHUNK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            c_in,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] s,
`ifdef PFA_OVF_EN
  output logic            c_out,
  output logic            ovf
`else
  output logic            c_out
`endif
);

  localparam int NCHUNK = SIZE / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [SIZE-1:0]  a_r, b_r;
  logic             carry_r;
  logic [IDX_W-1:0] idx;
  logic [CHUNK-1:0] sum;
  logic             cy;
  logic             accept, last;

  // State register only; all decisions live in the combinational block below.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    last       = (idx == LAST_IDX);
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One CHUNK-wide slice of the ripple; the carry is re-registered between slices.
  always_comb begin
    {cy, sum} = {1'b0, a_r[idx*CHUNK +: CHUNK]}
              + {1'b0, b_r[idx*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_r};
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      s       <= '0;
      c_out   <= 1'b0;
`ifdef PFA_OVF_EN
      ovf     <= 1'b0;
`endif
    end else if (accept) begin
      // Subtraction is a + ~b + ~borrow, so the BUSY path is a pure adder.
      a_r     <= a;
      b_r     <= sub ? ~b : b;
      carry_r <= sub ? ~c_in : c_in;
      idx     <= '0;
    end else if (state == BUSY) begin
      s[idx*CHUNK +: CHUNK] <= sum;
      carry_r               <= cy;
      if (last) begin
        idx   <= '0;
        c_out <= cy;
`ifdef PFA_OVF_EN
        ovf   <= (a_r[SIZE-1] == b_r[SIZE-1]) && (sum[CHUNK-1] != a_r[SIZE-1]);
`endif
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule
